mole_scheduler: RTL and testbench

- Sequences the mole game around the existing hit-detection block.
- Generates pseudo-random mole patterns on mole_positions and paces them with up/gap timers.
- Owns game_in_progress, the game countdown and the difficulty ramp.
- Consumes full_clear_hit and miss pulses from the hit-detection block to end a round early, speed up play, and count lives.

---
 rtl/mole_scheduler.sv | 160 ++++++++++++++++
 tb/tb_mole_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// Mole game sequencer: LFSR mole patterns, up/gap timing, game countdown and difficulty ramp.
// Optional lives (miss counting) enabled with `define SCHED_LIVES_EN.
module mole_scheduler #(
  parameter int          NUM_HOLES    = 18,
  parameter int          TICK_DIV     = 50000,
  parameter int          GAME_SECONDS = 30,
  parameter int          UP_MS_INIT   = 1500,
  parameter int          UP_MS_MIN    = 400,
  parameter int          UP_MS_STEP   = 100,
  parameter int          GAP_MS       = 300,
  parameter int          DOUBLE_ROUND = 8,
  parameter int          MAX_MISSES   = 5,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 full_clear_hit,
  input  logic                 miss,
  output logic [NUM_HOLES-1:0] mole_positions,
  output logic                 game_in_progress,
  output logic                 game_over,
  output logic [7:0]           time_left,
  output logic [7:0]           round_count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;

  typedef enum logic [1:0] {IDLE, GAP, UP, OVER} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc;
  logic [15:0]    ms_cnt, up_ms;
  logic [9:0]     sec_cnt;
  logic [15:0]    lfsr;
  logic [IW-1:0]  prev_idx;

  logic ms_tick, active, sec_wrap, time_expire, lives_out;
  logic load, to_up, round_end;

  assign ms_tick     = (presc == PW'(TICK_DIV - 1));
  assign active      = (state_q == GAP) || (state_q == UP);
  assign sec_wrap    = active && ms_tick && (sec_cnt == 10'd999);
  assign time_expire = sec_wrap && (time_left == 8'd1);

`ifdef SCHED_LIVES_EN
  logic [7:0] miss_cnt;
  assign lives_out = active && miss && (miss_cnt == 8'(MAX_MISSES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             miss_cnt <= '0;
    else if (load)                          miss_cnt <= '0;
    else if (active && miss && miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
  end
`else
  logic unused_miss;
  assign unused_miss = miss ^ (MAX_MISSES == 0);
  assign lives_out   = 1'b0;
`endif

  // Pattern pick: never repeat the previous primary hole.
  logic [15:0]          raw16, idx2_16;
  logic [IW-1:0]        raw_idx, idx;
  logic [NUM_HOLES-1:0] pattern;

  always_comb begin
    raw16   = {8'd0, lfsr[7:0]} % 16'(NUM_HOLES);
    raw_idx = raw16[IW-1:0];
    idx     = raw_idx;
    if (raw_idx == prev_idx)
      idx = (raw_idx == IW'(NUM_HOLES - 1)) ? '0 : raw_idx + 1'b1;
    idx2_16 = (16'(idx) + 16'(NUM_HOLES / 2)) % 16'(NUM_HOLES);
    pattern = {{(NUM_HOLES-1){1'b0}}, 1'b1} << idx;
    if (round_count >= 8'(DOUBLE_ROUND))
      pattern = pattern | ({{(NUM_HOLES-1){1'b0}}, 1'b1} << idx2_16[IW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    to_up     = 1'b0;
    round_end = 1'b0;
    case (state_q)
      IDLE, OVER: if (start) begin
        state_d = GAP;
        load    = 1'b1;
      end
      GAP: if (ms_tick && ms_cnt == 16'(GAP_MS - 1)) begin
        state_d = UP;
        to_up   = 1'b1;
      end
      UP: if (full_clear_hit || (ms_tick && ms_cnt == up_ms - 16'd1)) begin
        state_d   = GAP;
        round_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Game end wins over any round transition in the same cycle.
    if (active && (time_expire || lives_out)) begin
      state_d   = OVER;
      to_up     = 1'b0;
      round_end = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr             <= LFSR_SEED;
      presc            <= '0;
      ms_cnt           <= '0;
      sec_cnt          <= '0;
      up_ms            <= 16'(UP_MS_INIT);
      prev_idx         <= '0;
      mole_positions   <= '0;
      game_in_progress <= 1'b0;
      game_over        <= 1'b0;
      time_left        <= '0;
      round_count      <= '0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

      // Restart the ms grid on every state change so each interval gets whole ticks.
      if (state_d != state_q || ms_tick) presc <= '0;
      else                               presc <= presc + 1'b1;

      if (state_d != state_q) ms_cnt <= '0;
      else if (ms_tick)       ms_cnt <= ms_cnt + 16'd1;

      if (load)                    sec_cnt <= '0;
      else if (active && ms_tick)  sec_cnt <= (sec_cnt == 10'd999) ? 10'd0 : sec_cnt + 10'd1;

      if (load)          time_left <= 8'(GAME_SECONDS);
      else if (sec_wrap) time_left <= time_left - 8'd1;

      if (load)                                  round_count <= '0;
      else if (round_end && round_count != 8'hFF) round_count <= round_count + 8'd1;

      if (load)
        up_ms <= 16'(UP_MS_INIT);
      else if (round_end && full_clear_hit)
        up_ms <= (up_ms >= 16'(UP_MS_MIN + UP_MS_STEP)) ? up_ms - 16'(UP_MS_STEP)
                                                        : 16'(UP_MS_MIN);

      if (to_up) prev_idx <= idx;

      if (state_d != UP)  mole_positions <= '0;
      else if (to_up)     mole_positions <= pattern;

      game_in_progress <= (state_d == GAP) || (state_d == UP);
      game_over        <= (state_d == OVER) && (state_q != OVER);
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with small timing parameters.
module tb_mole_scheduler;
  localparam int NH = 18;
  localparam int TD = 4;
  localparam int GAP_CYC = 5 * TD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, full_clear_hit = 1'b0, miss = 1'b0;
  logic [NH-1:0] mole_positions;
  logic          game_in_progress, game_over;
  logic [7:0]    time_left, round_count;

  int checks = 0, errors = 0;
  int exp_rc = 0;
  logic [NH-1:0] pats[$];

  mole_scheduler #(
    .NUM_HOLES(NH), .TICK_DIV(TD), .GAME_SECONDS(2), .UP_MS_INIT(10), .UP_MS_MIN(6),
    .UP_MS_STEP(2), .GAP_MS(5), .DOUBLE_ROUND(8), .MAX_MISSES(3), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .full_clear_hit(full_clear_hit), .miss(miss),
    .mole_positions(mole_positions), .game_in_progress(game_in_progress),
    .game_over(game_over), .time_left(time_left), .round_count(round_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Count cycles while the mole pattern stays zero (want_nz=0) or nonzero (want_nz=1).
  task automatic measure(input logic want_nz, output int n);
    n = 0;
    while (((mole_positions != '0) == want_nz) && n < 1000) begin
      tick(); n++;
    end
    if (!want_nz) pats.push_back(mole_positions);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #12;
    checks++;
    if ({mole_positions, game_in_progress, game_over, time_left, round_count} !== '0) begin
      errors++; $display("FAIL reset_outputs got mole=%h gip=%b go=%b tl=%0d rc=%0d want all 0",
        mole_positions, game_in_progress, game_over, time_left, round_count);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (game_in_progress !== 1'b0 || mole_positions !== '0) begin
      errors++; $display("FAIL idle_outputs got gip=%b mole=%h want 0", game_in_progress, mole_positions);
    end
  endtask

  task automatic test_start();
    int n;
    pulse_start();
    checks++;
    if (game_in_progress !== 1'b1 || time_left !== 8'd2 || round_count !== 8'd0 || mole_positions !== '0) begin
      errors++; $display("FAIL start_load got gip=%b tl=%0d rc=%0d mole=%h want 1/2/0/0",
        game_in_progress, time_left, round_count, mole_positions);
    end
    measure(1'b0, n);
    checks++;
    if (n != GAP_CYC) begin errors++; $display("FAIL first_gap_len got %0d want %0d", n, GAP_CYC); end
    checks++;
    if ($countones(mole_positions) != 1) begin
      errors++; $display("FAIL first_pattern got %h want one bit", mole_positions);
    end
  endtask

  task automatic test_timeout();
    int n;
    measure(1'b1, n);
    checks++;
    if (n != 40) begin errors++; $display("FAIL timeout_up_len got %0d want 40", n); end
    exp_rc++;
    checks++;
    if (round_count !== 8'(exp_rc) || mole_positions !== '0) begin
      errors++; $display("FAIL timeout_round got rc=%0d mole=%h want rc=%0d mole=0", round_count, mole_positions, exp_rc);
    end
    measure(1'b0, n);
    measure(1'b1, n);
    checks++;
    if (n != 40) begin errors++; $display("FAIL second_up_len got %0d want 40", n); end
    exp_rc++;
  endtask

  task automatic test_start_ignored();
    int n;
    pulse_start();
    measure(1'b0, n);
    checks++;
    if (n != GAP_CYC - 1 || round_count !== 8'(exp_rc) || time_left !== 8'd2) begin
      errors++; $display("FAIL start_in_gap got gap_rest=%0d rc=%0d tl=%0d want %0d/%0d/2",
        n, round_count, time_left, GAP_CYC - 1, exp_rc);
    end
  endtask

  // Each hit shortens the next UP by 2 ms until the 6 ms floor.
  task automatic test_full_clear();
    int n;
    int want_up[3] = '{32, 24, 24};
    for (int k = 0; k < 3; k++) begin
      if (k != 0) measure(1'b0, n);
      repeat (3) tick();
      full_clear_hit = 1'b1; tick(); full_clear_hit = 1'b0;
      exp_rc++;
      checks++;
      if (mole_positions !== '0 || round_count !== 8'(exp_rc)) begin
        errors++; $display("FAIL clear_%0d got mole=%h rc=%0d want 0/%0d", k, mole_positions, round_count, exp_rc);
      end
      measure(1'b0, n);
      checks++;
      if (n != GAP_CYC) begin errors++; $display("FAIL clear_gap_%0d got %0d want %0d", k, n, GAP_CYC); end
      measure(1'b1, n);
      checks++;
      if (n != want_up[k]) begin errors++; $display("FAIL clear_up_len_%0d got %0d want %0d", k, n, want_up[k]); end
      exp_rc++;
    end
  endtask

  task automatic test_double_no_repeat();
    int n, lo;
    logic [NH-1:0] p, want;
    while (exp_rc < 11) begin
      measure(1'b0, n);
      measure(1'b1, n);
      exp_rc++;
    end
    checks++;
    if (round_count !== 8'(exp_rc)) begin
      errors++; $display("FAIL round_count got %0d want %0d", round_count, exp_rc);
    end
    for (int r = 0; r < pats.size(); r++) begin
      p = pats[r];
      checks++;
      if (r < 8) begin
        if ($countones(p) != 1 || (r > 0 && p == pats[r-1])) begin
          errors++; $display("FAIL single_round_%0d got %h prev %h want one new bit", r, p, (r > 0) ? pats[r-1] : '0);
        end
      end else begin
        lo = 0;
        for (int b = NH - 1; b >= 0; b--) if (p[b]) lo = b;
        want = '0;
        if (lo < NH / 2) begin want[lo] = 1'b1; want[lo + NH/2] = 1'b1; end
        if (p !== want) begin
          errors++; $display("FAIL double_round_%0d got %h want %h", r, p, want);
        end
      end
    end
  endtask

  task automatic test_game_end();
    int n = 0;
    logic [7:0] rc_at_end;
    while (game_over !== 1'b1 && n < 20000) begin tick(); n++; end
    checks++;
    if (game_over !== 1'b1 || game_in_progress !== 1'b0 || mole_positions !== '0 || time_left !== 8'd0) begin
      errors++; $display("FAIL game_end got go=%b gip=%b mole=%h tl=%0d want 1/0/0/0",
        game_over, game_in_progress, mole_positions, time_left);
    end
    rc_at_end = round_count;
    tick();
    checks++;
    if (game_over !== 1'b0) begin errors++; $display("FAIL game_over_width got %b want 0", game_over); end
    repeat (10) tick();
    checks++;
    if (round_count !== rc_at_end || time_left !== 8'd0 || game_in_progress !== 1'b0) begin
      errors++; $display("FAIL over_hold got rc=%0d tl=%0d gip=%b want %0d/0/0", round_count, time_left, game_in_progress, rc_at_end);
    end
    pulse_start();
    checks++;
    if (time_left !== 8'd2 || round_count !== 8'd0 || game_in_progress !== 1'b1) begin
      errors++; $display("FAIL restart got tl=%0d rc=%0d gip=%b want 2/0/1", time_left, round_count, game_in_progress);
    end
  endtask

  task automatic test_lives();
    for (int k = 0; k < 3; k++) begin
      repeat (2) tick();
      miss = 1'b1; tick(); miss = 1'b0;
      if (k == 1) begin
        checks++;
        if (game_in_progress !== 1'b1) begin errors++; $display("FAIL two_misses got gip=%b want 1", game_in_progress); end
      end
    end
    checks++;
`ifdef SCHED_LIVES_EN
    if (game_over !== 1'b1 || game_in_progress !== 1'b0) begin
      errors++; $display("FAIL lives_over got go=%b gip=%b want 1/0", game_over, game_in_progress);
    end
`else
    if (game_over !== 1'b0 || game_in_progress !== 1'b1) begin
      errors++; $display("FAIL miss_ignored got go=%b gip=%b want 0/1", game_over, game_in_progress);
    end
`endif
  endtask

  task automatic test_reset_mid_game();
    if (game_in_progress !== 1'b1) pulse_start();
    repeat (30) tick();
    rst_n = 1'b0; #1;
    checks++;
    if (game_in_progress !== 1'b0 || game_over !== 1'b0 || mole_positions !== '0 || time_left !== 8'd0) begin
      errors++; $display("FAIL reset_mid got gip=%b go=%b mole=%h tl=%0d want 0", game_in_progress, game_over, mole_positions, time_left);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (game_over !== 1'b0 || game_in_progress !== 1'b0) begin
      errors++; $display("FAIL after_reset got go=%b gip=%b want 0/0", game_over, game_in_progress);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_timeout();
    test_start_ignored();
    test_full_clear();
    test_double_no_repeat();
    test_game_end();
    test_lives();
    test_reset_mid_game();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
